// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch program-counter sequencer (BOOT/RUN/HALTED) with trap, redirect and stall handling.
// Optional halt-detect at HALT_ADDR is enabled by defining the macro PC_HALT_EN.

module pc_sequencer #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
  parameter logic [XLEN-1:0] HALT_ADDR    = XLEN'(32'h0000_004C)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [XLEN-1:0] pc_target,
  input  logic            pc_src,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            fetch_ready,
  input  logic            resume,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus_4,
  output logic            fetch_valid,
  output logic            misaligned,
  output logic [XLEN-1:0] trap_epc,
  output logic            halted
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_e;

  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] epc_q;
  logic            fetch_valid_q;
  logic            misaligned_q;
`ifdef PC_HALT_EN
  logic            halted_q;
`endif

  logic [XLEN-1:0] trap_pc;
  logic            target_misaligned;
  logic            unused_inputs;

  // Handler addresses are word aligned; the low vector bits never reach pc.
  assign trap_pc           = {trap_vector[XLEN-1:2], 2'b00};
  assign target_misaligned = (pc_target[1:0] != 2'b00);
  assign unused_inputs     = ^{resume, trap_vector[1:0]};

  // Wraps naturally modulo 2^XLEN.
  assign pc_plus_4 = pc_q + XLEN'(4);

  // NOTE: async reset sits in the sensitivity list so every output clears the
  // moment reset_n falls, with no clock required.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= BOOT;
      pc_q          <= RESET_VECTOR;
      epc_q         <= '0;
      fetch_valid_q <= 1'b0;
      misaligned_q  <= 1'b0;
`ifdef PC_HALT_EN
      halted_q      <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below reads
      // the pre-edge pc_q and the last assignment in a branch wins cleanly.
      misaligned_q <= 1'b0;
      case (state_q)
        BOOT: begin
          state_q       <= RUN;
          fetch_valid_q <= 1'b1;
        end

        RUN: begin
          if (trap_req) begin
            pc_q  <= trap_pc;
            epc_q <= pc_q;
          end else if (pc_src && target_misaligned) begin
            pc_q         <= trap_pc;
            epc_q        <= pc_q;
            misaligned_q <= 1'b1;
          end else if (pc_src) begin
            pc_q <= pc_target;
`ifdef PC_HALT_EN
          end else if (fetch_ready && (pc_q == HALT_ADDR)) begin
            state_q       <= HALTED;
            fetch_valid_q <= 1'b0;
            halted_q      <= 1'b1;
`endif
          end else if (fetch_ready) begin
            pc_q <= pc_plus_4;
          end
        end

        HALTED: begin
`ifdef PC_HALT_EN
          // Redirects are meaningless while halted; only trap or resume wake us.
          if (trap_req) begin
            state_q       <= RUN;
            pc_q          <= trap_pc;
            epc_q         <= HALT_ADDR;
            fetch_valid_q <= 1'b1;
            halted_q      <= 1'b0;
          end else if (resume) begin
            state_q       <= RUN;
            pc_q          <= HALT_ADDR + XLEN'(4);
            fetch_valid_q <= 1'b1;
            halted_q      <= 1'b0;
          end
`else
          state_q       <= BOOT;
          fetch_valid_q <= 1'b0;
`endif
        end

        default: begin
          state_q       <= BOOT;
          fetch_valid_q <= 1'b0;
`ifdef PC_HALT_EN
          halted_q      <= 1'b0;
`endif
        end
      endcase
    end
  end

  assign pc          = pc_q;
  assign trap_epc    = epc_q;
  assign fetch_valid = fetch_valid_q;
  assign misaligned  = misaligned_q;
`ifdef PC_HALT_EN
  assign halted      = halted_q;
`else
  assign halted      = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized traffic against a behavioural model.
// Halt scenarios are exercised when PC_HALT_EN is defined; otherwise halted must stay 0.

module tb_pc_sequencer;

`ifdef PC_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif
  localparam logic [31:0] RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] HALT_PC   = 32'h0000_004C;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] pc_target;
  logic        pc_src;
  logic        trap_req;
  logic [31:0] trap_vector;
  logic        fetch_ready;
  logic        resume;
  logic [31:0] pc;
  logic [31:0] pc_plus_4;
  logic        fetch_valid;
  logic        misaligned;
  logic [31:0] trap_epc;
  logic        halted;

  int total = 0;
  int bad   = 0;

  // Behavioural model: where the fetch stream is, what was last trapped from,
  // and whether we are still in the post-reset slot or parked at the halt address.
  logic [31:0] m_pc;
  logic [31:0] m_epc;
  bit          m_mis;
  bit          m_boot;
  bit          m_halt;

  pc_sequencer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pc_target  (pc_target),
    .pc_src     (pc_src),
    .trap_req   (trap_req),
    .trap_vector(trap_vector),
    .fetch_ready(fetch_ready),
    .resume     (resume),
    .pc         (pc),
    .pc_plus_4  (pc_plus_4),
    .fetch_valid(fetch_valid),
    .misaligned (misaligned),
    .trap_epc   (trap_epc),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc   = RESET_VEC;
    m_epc  = 32'h0;
    m_mis  = 1'b0;
    m_boot = 1'b1;
    m_halt = 1'b0;
  endtask

  // One clock of the architectural rules, applied to the inputs seen at the edge.
  task automatic model_step();
    logic [31:0] vec;
    vec   = trap_vector & 32'hFFFF_FFFC;
    m_mis = 1'b0;
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_halt) begin
      if (trap_req) begin
        m_epc = HALT_PC; m_pc = vec; m_halt = 1'b0;
      end else if (resume) begin
        m_pc = HALT_PC + 32'd4; m_halt = 1'b0;
      end
    end else if (trap_req) begin
      m_epc = m_pc; m_pc = vec;
    end else if (pc_src && (pc_target % 4 != 0)) begin
      m_epc = m_pc; m_pc = vec; m_mis = 1'b1;
    end else if (pc_src) begin
      m_pc = pc_target;
    end else if (fetch_ready) begin
      if (HALT_EN && m_pc == HALT_PC) m_halt = 1'b1;
      else m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},          pc,                 m_pc);
    check({tag, ".pc_plus_4"},   pc_plus_4,          m_pc + 32'd4);
    check({tag, ".fetch_valid"}, {31'b0, fetch_valid}, {31'b0, !(m_boot || m_halt)});
    check({tag, ".misaligned"},  {31'b0, misaligned},  {31'b0, m_mis});
    check({tag, ".trap_epc"},    trap_epc,           m_epc);
    check({tag, ".halted"},      {31'b0, halted},      {31'b0, m_halt});
  endtask

  // Drive inputs away from the edge, clock once, then compare 1 time unit later.
  task automatic cycle(input string tag, input logic src, input logic [31:0] tgt,
                       input logic trap, input logic [31:0] tv, input logic rdy,
                       input logic res);
    pc_src      = src;
    pc_target   = tgt;
    trap_req    = trap;
    trap_vector = tv;
    fetch_ready = rdy;
    resume      = res;
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  // Assert reset mid-cycle, confirm outputs clear without an edge, then release.
  task automatic async_reset(input string tag);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check({tag, ".pc_now"},     pc,                   RESET_VEC);
    check({tag, ".halted_now"}, {31'b0, halted},      32'h0);
    check({tag, ".fv_now"},     {31'b0, fetch_valid}, 32'h0);
    check({tag, ".epc_now"},    trap_epc,             32'h0);
    check({tag, ".mis_now"},    {31'b0, misaligned},  32'h0);
    @(posedge clk);
    #2;
    check_all({tag, ".held"});
    reset_n = 1'b1;
    #1;
    check_all({tag, ".boot"});
  endtask

  initial begin
    logic [31:0] tgt;
    logic [31:0] tv;
    reset_n     = 1'b0;
    pc_target   = 32'h0;
    pc_src      = 1'b0;
    trap_req    = 1'b0;
    trap_vector = 32'h0;
    fetch_ready = 1'b0;
    resume      = 1'b0;
    model_reset();

    #3;
    check("rst.pc",          pc,                   RESET_VEC);
    check("rst.fetch_valid", {31'b0, fetch_valid}, 32'h0);
    check("rst.misaligned",  {31'b0, misaligned},  32'h0);
    check("rst.halted",      {31'b0, halted},      32'h0);
    check("rst.trap_epc",    trap_epc,             32'h0);

    // Reset and BOOT
    #9;
    reset_n = 1'b1;
    #1;
    check_all("boot0");
    cycle("boot1", 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    check("boot1.pc_lit", pc, 32'h0);
    check("boot1.fv_lit", {31'b0, fetch_valid}, 32'h1);
    cycle("seq4", 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    check("seq4.pc_lit", pc, 32'h4);
    cycle("seq8", 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    check("seq8.pc_lit", pc, 32'h8);

    // Stall then redirect
    cycle("seqC",  1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    cycle("seq10", 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle("stall", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      check("stall.pc_lit", pc, 32'h10);
    end
    cycle("flush", 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
    check("flush.pc_lit", pc, 32'h40);

    // Priority and misalignment
    cycle("to20", 1'b1, 32'h20, 1'b0, 32'h0, 1'b0, 1'b0);
    cycle("trap_pri", 1'b1, 32'h40, 1'b1, 32'h103, 1'b1, 1'b0);
    check("trap_pri.pc_lit",  pc,       32'h100);
    check("trap_pri.epc_lit", trap_epc, 32'h20);
    check("trap_pri.mis_lit", {31'b0, misaligned}, 32'h0);
    cycle("seq104", 1'b0, 32'h0, 1'b0, 32'h103, 1'b1, 1'b0);
    cycle("misal", 1'b1, 32'h46, 1'b0, 32'h103, 1'b0, 1'b0);
    check("misal.pc_lit",  pc,       32'h100);
    check("misal.epc_lit", trap_epc, 32'h104);
    check("misal.mis_lit", {31'b0, misaligned}, 32'h1);
    cycle("misal_end", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("misal_end.mis_lit", {31'b0, misaligned}, 32'h0);

    // Wrap
    cycle("to_top", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 1'b0);
    check("to_top.p4_lit", pc_plus_4, 32'h0);
    cycle("wrap", 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    check("wrap.pc_lit", pc, 32'h0);

    // Run up to the halt address
    cycle("to40", 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle("run_halt", 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
`ifdef PC_HALT_EN
    check("halt.halted_lit", {31'b0, halted},      32'h1);
    check("halt.fv_lit",     {31'b0, fetch_valid}, 32'h0);
    for (int i = 0; i < 10; i++) begin
      cycle("halt_hold", i[0], 32'h80, 1'b0, 32'h0, 1'($urandom_range(0, 1)), 1'b0);
      check("halt_hold.pc_lit", pc, HALT_PC);
    end
    cycle("resume", 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
    check("resume.pc_lit",     pc,              32'h50);
    check("resume.halted_lit", {31'b0, halted}, 32'h0);
    cycle("to4C", 1'b1, HALT_PC, 1'b0, 32'h0, 1'b0, 1'b0);
    cycle("rehalt", 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    cycle("halt_trap", 1'b1, 32'h80, 1'b1, 32'h203, 1'b0, 1'b1);
    check("halt_trap.pc_lit",  pc,       32'h200);
    check("halt_trap.epc_lit", trap_epc, HALT_PC);
    cycle("to4C_b", 1'b1, HALT_PC, 1'b0, 32'h0, 1'b0, 1'b0);
    cycle("rehalt_b", 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
`else
    check("nohalt.halted_lit", {31'b0, halted}, 32'h0);
    check("nohalt.pc_lit",     pc,              32'h50);
    cycle("nohalt_resume", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    check("nohalt_resume.pc_lit", pc, 32'h50);
`endif

    // Async reset mid-cycle (in HALTED when the halt feature is built in)
    async_reset("areset");
    cycle("post_rst", 1'b1, 32'h80, 1'b1, 32'h300, 1'b1, 1'b0);
    check("post_rst.pc_lit", pc, 32'h0);

    // Randomized traffic, with an occasional mid-run reset
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 7))
        0:       tgt = HALT_PC;
        1:       tgt = 32'hFFFF_FFFC;
        2:       tgt = $urandom() | 32'h1;
        3:       tgt = 32'h40;
        default: tgt = $urandom() & 32'hFFFF_FFFC;
      endcase
      tv = $urandom();
      cycle("rand", ($urandom_range(0, 7) == 0), tgt, ($urandom_range(0, 15) == 0), tv,
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0));
      if (i % 200 == 199) async_reset("rand_rst");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have the following parameters, one per line (name, default, meaning):
- XLEN, 32, address width.
- RESET_VECTOR, 32'h0000_0000, first fetch address.
- HALT_ADDR, 32'h0000_004C, halt-detect address.
REQ-002 The block SHALL have the following ports, one per line (name, direction, width, meaning):
- clk, in, 1, single clock; all state updates on rising edge.
- reset_n, in, 1, asynchronous active-low reset.
- pc_target, in, XLEN, branch/jump target.
- pc_src, in, 1, redirect request: 1 = take pc_target.
- trap_req, in, 1, trap request.
- trap_vector, in, XLEN, trap handler address; bits[1:0] treated as 0.
- fetch_ready, in, 1, fetch stage accepts the current pc.
- resume, in, 1, leave HALTED.
- pc, out, XLEN, current fetch address.
- pc_plus_4, out, XLEN, pc + 4, combinational.
- fetch_valid, out, 1, pc is a valid fetch request.
- misaligned, out, 1, one-cycle pulse: redirect target misaligned.
- trap_epc, out, XLEN, pc captured when a trap or misalignment was taken.
- halted, out, 1, state == HALTED.

Function
REQ-003 The FSM SHALL have three states, BOOT, RUN and HALTED; fetch_valid SHALL be 1 only in RUN.
REQ-004 BOOT SHALL last exactly one cycle after reset release, then go to RUN with pc unchanged (RESET_VECTOR).
REQ-005 In RUN, the next pc SHALL be chosen by fixed priority, from highest to lowest:
- trap_req;
- misaligned redirect;
- aligned redirect;
- sequential;
- hold.
REQ-006 When trap_req=1 in RUN, pc SHALL become {trap_vector[XLEN-1:2],2'b00} and trap_epc SHALL become the old pc, regardless of fetch_ready.
REQ-007 When pc_src=1, trap_req=0 and pc_target[1:0]!=0, pc SHALL become the aligned trap_vector, trap_epc SHALL become the old pc, and misaligned SHALL be 1 for exactly the following cycle.
REQ-008 When pc_src=1 with aligned pc_target and trap_req=0, pc SHALL become pc_target next cycle, regardless of fetch_ready (flush).
REQ-009 With no redirect or trap, pc SHALL advance to pc_plus_4 only when fetch_ready=1; otherwise pc SHALL hold (stall).
REQ-010 pc_plus_4 SHALL wrap modulo 2^XLEN (0xFFFF_FFFC -> 0x0000_0000), with no flag.
REQ-011 In BOOT, pc_src, trap_req and fetch_ready SHALL be ignored.
REQ-012 trap_epc SHALL hold its value between captures.

Reset
REQ-013 reset_n=0 SHALL asynchronously force the following:
- pc = RESET_VECTOR;
- state = BOOT;
- fetch_valid = 0, misaligned = 0, halted = 0;
- trap_epc = 0.
REQ-014 Reset assertion mid-operation, including in HALTED or during a stall, SHALL take effect immediately and discard any pending redirect.
REQ-015 Reset deassertion SHALL be synchronous to clk; it is synchronised outside this block.

Configuration
REQ-016 With macro PC_HALT_EN defined, the following SHALL apply:
- RUN SHALL go to HALTED when pc==HALT_ADDR, fetch_ready=1 and no redirect or trap is pending; pc SHALL hold HALT_ADDR.
- In HALTED, trap_req SHALL go to RUN with pc = aligned trap_vector and trap_epc = HALT_ADDR.
- In HALTED, resume (lower priority than trap_req) SHALL go to RUN with pc = HALT_ADDR+4.
- In HALTED, pc_src SHALL be ignored.
REQ-017 Without PC_HALT_EN, HALTED SHALL be unreachable, halted SHALL be tied to 0, and resume SHALL be ignored.

Verification
REQ-018 The bench SHALL cover at least the following directed scenarios:
- Reset and BOOT: release reset_n, fetch_ready=1 -> cycle 1 fetch_valid=0 with pc=0; then pc = 0, 4, 8 with fetch_valid=1.
- Stall then redirect: pc=0x10, fetch_ready=0 for 3 cycles -> pc holds 0x10; then pc_src=1, pc_target=0x40 with fetch_ready=0 -> pc=0x40 next cycle.
- Priority and misalignment: trap_req=1 together with pc_src=1 at pc=0x20, trap_vector=0x103 -> pc=0x100, trap_epc=0x20, misaligned=0. Then pc_src=1, pc_target=0x46 at pc=0x104 -> pc=0x100, trap_epc=0x104, misaligned pulses once.
- Wrap: pc_target=0xFFFF_FFFC, then fetch_ready=1 -> pc=0x0000_0000.
- Halt (PC_HALT_EN): run to 0x4C -> halted=1, fetch_valid=0, pc stays 0x4C for 10 cycles with pc_src toggling. Then resume=1 -> pc=0x50, halted=0.
- Async reset: assert reset_n=0 mid-cycle in HALTED -> pc=0 and halted=0 immediately, without waiting for a clock edge.
